fifo_rd_ctrl: RTL and testbench

Read-domain controller of the dual-clock gray-pointer FIFO; the counterpart of the write-side full logic.
- Owns the read pointer, in binary and gray form.
- Synchronises the write-side gray pointer into the read clock domain and produces a registered empty flag.
- Drives the RAM read address.
- Exports its registered gray pointer to the write domain, where it becomes rd_ptr_gray_sync.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sync_ff.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 88 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared gray-pointer FIFO helpers for the read and write domains.
// Conversions work on a wide zero-extended vector, so one function serves every pointer width.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros above the real width leave the lower result bits untouched.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Plain multi-flop synchroniser chain with synchronous active-high reset.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Straight flop-to-flop path; nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer, empty and underflow logic of the dual-clock gray-pointer FIFO.
// Optional macro FIFO_RD_COUNT_EN adds a registered rd_count occupancy output.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH  = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         rd_en,
    input  logic [$clog2(FIFO_DEPTH):0]  wr_ptr_gray,
    output logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
    output logic [$clog2(FIFO_DEPTH):0]  rd_ptr_gray,
    output logic                         empty,
    output logic                         rd_valid,
    output logic                         underflow
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0]  rd_count
`endif
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ptr_width(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("fifo_rd_ctrl: FIFO_DEPTH must be a power of two");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_sync_check
        $error("fifo_rd_ctrl: SYNC_STAGES must be 2..4");
    end

    logic [PTR_W-1:0] rd_ptr_bin;
    logic [PTR_W-1:0] rd_ptr_bin_next;
    logic [PTR_W-1:0] rd_ptr_gray_next;
    logic [PTR_W-1:0] wr_ptr_gray_sync;
    logic             rd_fire;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (PTR_W)
    ) u_wr_ptr_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wr_ptr_gray),
        .q   (wr_ptr_gray_sync)
    );

    assign rd_fire          = rd_en & ~empty;
    assign rd_ptr_bin_next  = rd_ptr_bin + PTR_W'(rd_fire);
    assign rd_ptr_gray_next = PTR_W'(bin2gray(MAX_PTR_W'(rd_ptr_bin_next)));

    // Empty compares the post-read pointer, so the final read raises empty on its own edge.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            empty       <= 1'b1;
            rd_valid    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            rd_ptr_bin  <= rd_ptr_bin_next;
            rd_ptr_gray <= rd_ptr_gray_next;
            empty       <= (rd_ptr_gray_next == wr_ptr_gray_sync);
            rd_valid    <= rd_fire;
            underflow   <= rd_en & empty;
        end
    end

    assign rd_addr = rd_ptr_bin[ADDR_W-1:0];

`ifdef FIFO_RD_COUNT_EN
    logic [PTR_W-1:0] wr_ptr_bin_sync;

    assign wr_ptr_bin_sync = PTR_W'(gray2bin(MAX_PTR_W'(wr_ptr_gray_sync)));

    // Same operands as the empty compare, so a zero count coincides exactly with empty.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_count <= '0;
        end else begin
            rd_count <= wr_ptr_bin_sync - rd_ptr_bin_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl at FIFO_DEPTH=16, SYNC_STAGES=2 (5-bit pointers).
module tb_fifo_rd_ctrl;

    typedef struct {
        string      name;
        logic       empty;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       valid;
        logic       under;
        logic [4:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rd_rst = 1'b1;
    logic       rd_en = 1'b0;
    logic [4:0] wr_ptr_gray = 5'd0;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr_gray;
    logic       empty;
    logic       rd_valid;
    logic       underflow;
`ifdef FIFO_RD_COUNT_EN
    logic [4:0] rd_count;
`endif

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Hand-written 5-bit gray sequence for binary 0..31.
    logic [4:0] grayTab [32] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100,
        5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000,
        5'b11000, 5'b11001, 5'b11011, 5'b11010, 5'b11110, 5'b11111, 5'b11101, 5'b11100,
        5'b10100, 5'b10101, 5'b10111, 5'b10110, 5'b10010, 5'b10011, 5'b10001, 5'b10000
    };

    fifo_rd_ctrl #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .rd_en       (rd_en),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_addr     (rd_addr),
        .rd_ptr_gray (rd_ptr_gray),
        .empty       (empty),
        .rd_valid    (rd_valid),
        .underflow   (underflow)
`ifdef FIFO_RD_COUNT_EN
        ,
        .rd_count    (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // One rd_clk cycle of inputs plus the outputs expected right after its rising edge.
    task automatic applyStimulus(input string name, input logic rst, input logic en,
                                 input logic [4:0] wg, input logic expEmpty, input int reads,
                                 input logic expValid, input logic expUnder, input int expCnt);
        exp_t e;
        @(negedge clk);
        #1;
        rd_rst      = rst;
        rd_en       = en;
        wr_ptr_gray = wg;
        e.name  = name;
        e.empty = expEmpty;
        e.addr  = 4'(reads % 16);
        e.gray  = grayTab[reads % 32];
        e.valid = expValid;
        e.under = expUnder;
        e.cnt   = 5'(expCnt);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic bad;
        bad = (empty !== e.empty) || (rd_addr !== e.addr) || (rd_ptr_gray !== e.gray) ||
              (rd_valid !== e.valid) || (underflow !== e.under);
`ifdef FIFO_RD_COUNT_EN
        if (rd_count !== e.cnt) bad = 1'b1;
`endif
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got empty=%b addr=%0d gray=%b valid=%b under=%b, want empty=%b addr=%0d gray=%b valid=%b under=%b cnt=%0d",
                     e.name, empty, rd_addr, rd_ptr_gray, rd_valid, underflow,
                     e.empty, e.addr, e.gray, e.valid, e.under, e.cnt);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int r;
        // Reset with rd_en high and a non-zero write pointer, then watch the synchroniser catch up.
        applyStimulus("t1_reset", 1, 1, 5'b00011, 1, 0, 0, 0, 0);
        applyStimulus("t1_release", 0, 0, 5'b00011, 1, 0, 0, 0, 0);
        applyStimulus("t1_sync", 0, 0, 5'b00011, 1, 0, 0, 0, 0);
        applyStimulus("t1_not_empty", 0, 0, 5'b00011, 0, 0, 0, 0, 2);

        // Single write then single read of the last word.
        applyStimulus("t2_reset", 1, 0, 5'b00000, 1, 0, 0, 0, 0);
        applyStimulus("t2_wr_n", 0, 0, 5'b00001, 1, 0, 0, 0, 0);
        applyStimulus("t2_wr_n1", 0, 0, 5'b00001, 1, 0, 0, 0, 0);
        applyStimulus("t2_wr_n2", 0, 0, 5'b00001, 0, 0, 0, 0, 1);
        applyStimulus("t2_read", 0, 1, 5'b00001, 1, 1, 1, 0, 0);
        applyStimulus("t2_valid_drop", 0, 0, 5'b00001, 1, 1, 0, 0, 0);

        // Reads while empty only raise underflow.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t3_underflow", 0, 1, 5'b00001, 1, 1, 0, 1, 0);
        end
        applyStimulus("t3_clear", 0, 0, 5'b00001, 1, 1, 0, 0, 0);

        // Full FIFO drained back to back.
        applyStimulus("t4_reset", 1, 0, 5'b00000, 1, 0, 0, 0, 0);
        applyStimulus("t4_wr_n", 0, 0, 5'b11000, 1, 0, 0, 0, 0);
        applyStimulus("t4_wr_n1", 0, 0, 5'b11000, 1, 0, 0, 0, 0);
        applyStimulus("t4_full", 0, 0, 5'b11000, 0, 0, 0, 0, 16);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus("t4_read", 0, 1, 5'b11000, (i == 16), i, 1, 0, 16 - i);
        end
        applyStimulus("t4_drained", 0, 0, 5'b11000, 1, 16, 0, 0, 0);

        // Write/read pairs in step, wrapping the pointer through bin 31 back to 0.
        for (int k = 0; k < 32; k++) begin
            r = 16 + k;
            applyStimulus("t5_wr", 0, 0, grayTab[(r + 1) % 32], 1, r, 0, 0, 0);
            applyStimulus("t5_sync", 0, 0, grayTab[(r + 1) % 32], 1, r, 0, 0, 0);
            applyStimulus("t5_ready", 0, 0, grayTab[(r + 1) % 32], 0, r, 0, 0, 1);
            applyStimulus("t5_read", 0, 1, grayTab[(r + 1) % 32], 1, r + 1, 1, 0, 0);
        end

        // Reset in the middle of draining ten buffered words.
        applyStimulus("t6_reset", 1, 0, 5'b00000, 1, 0, 0, 0, 0);
        applyStimulus("t6_wr_n", 0, 0, 5'b01111, 1, 0, 0, 0, 0);
        applyStimulus("t6_wr_n1", 0, 0, 5'b01111, 1, 0, 0, 0, 0);
        applyStimulus("t6_ready", 0, 0, 5'b01111, 0, 0, 0, 0, 10);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus("t6_read", 0, 1, 5'b01111, 0, i, 1, 0, 10 - i);
        end
        applyStimulus("t6_mid_reset", 1, 1, 5'b01111, 1, 0, 0, 0, 0);
        applyStimulus("t6_after", 0, 0, 5'b01111, 1, 0, 0, 0, 0);
        applyStimulus("t6_sync", 0, 0, 5'b01111, 1, 0, 0, 0, 0);
        applyStimulus("t6_refill", 0, 0, 5'b01111, 0, 0, 0, 0, 10);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
